// File: rtl/ni_pkg.sv
// Shared definitions for the Wishbone-to-NoC master bridge: flit layout, port codes,
// FSM states, header field widths and the address-region to mesh-coordinate map.
package ni_pkg;
  localparam int FLIT_W      = 36;
  localparam int FLIT_VALID  = 0;
  localparam int FLIT_VC     = 1;
  localparam int FLIT_HEAD   = 2;
  localparam int FLIT_TAIL   = 3;
  localparam int FLIT_PL_LSB = 4;
  localparam int PAYLOAD_W   = 32;
  localparam int HDR_PORT_W  = 3;
  localparam int HDR_CTRL_W  = 7;  // cyc, stb, we, sel[4]

  localparam logic [2:0] PORT_WEST  = 3'd0;
  localparam logic [2:0] PORT_EAST  = 3'd1;
  localparam logic [2:0] PORT_SOUTH = 3'd2;
  localparam logic [2:0] PORT_NORTH = 3'd3;
  localparam logic [2:0] PORT_LOCAL = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_DATA,
    ST_WAIT,
    ST_RESP
  } ni_state_e;

  typedef struct packed {
    logic       mapped;
    logic [7:0] x;
    logic [7:0] y;
  } region_t;

  function automatic region_t region_decode(input logic [3:0] region);
    region_t r;
    r        = '0;
    r.mapped = 1'b1;
    case (region)
      4'd0:    begin r.x = 8'd1; r.y = 8'd1; end
      4'd1:    begin r.x = 8'd2; r.y = 8'd1; end
      4'd2:    begin r.x = 8'd0; r.y = 8'd1; end
      4'd3:    begin r.x = 8'd1; r.y = 8'd0; end
      4'd4:    begin r.x = 8'd1; r.y = 8'd2; end
      default: r.mapped = 1'b0;
    endcase
    return r;
  endfunction

  // XY routing: resolve X first, then Y.
  function automatic logic [2:0] xy_port(input logic [7:0] dx, input logic [7:0] dy,
                                         input logic [7:0] mx, input logic [7:0] my);
    if (dx > mx) return PORT_EAST;
    if (dx < mx) return PORT_WEST;
    if (dy > my) return PORT_NORTH;
    if (dy < my) return PORT_SOUTH;
    return PORT_LOCAL;
  endfunction

  function automatic logic [FLIT_W-1:0] make_flit(input logic [PAYLOAD_W-1:0] pl,
                                                  input logic tail, input logic head,
                                                  input logic vc);
    return {pl, tail, head, vc, 1'b1};
  endfunction
endpackage

// File: rtl/ni_credit_counter.sv
// Saturating per-VC credit counter: take on flit load, give on a credit return pulse.
module ni_credit_counter #(
  parameter  int DEPTH = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          take,
  input  logic          give,
  output logic [CW-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= CW'(DEPTH);
    end else if (take && !give && count != '0) begin
      count <= count - 1'b1;
    end else if (give && !take && count != CW'(DEPTH)) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/ni_wb_master_bridge.sv
// Wishbone slave to NoC bridge for a bus master: one outstanding request, per-VC credits.
// Optional reply timeout is enabled by defining NI_RESP_TIMEOUT_EN.
module ni_wb_master_bridge import ni_pkg::*; #(
  parameter  int MY_X         = 0,
  parameter  int MY_Y         = 0,
  parameter  int COORD_W      = 2,
  parameter  int CREDIT_DEPTH = 3,
  parameter  int TIMEOUT_CYC  = 1024,
  localparam int CW           = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [31:0]       wb_dat_o,
  output logic [FLIT_W-1:0] channel_out,
  input  logic [FLIT_W-1:0] channel_in,
  input  logic [1:0]        flow_ctrl_in,
  output logic [1:0]        flow_ctrl_out,
  output ni_state_e         dbg_state,
  output logic [CW-1:0]     dbg_credit_vc0,
  output logic [CW-1:0]     dbg_credit_vc1
);
  localparam int ADR_W   = PAYLOAD_W - HDR_PORT_W - 4 * COORD_W - HDR_CTRL_W;
  localparam int DX_LSB  = PAYLOAD_W - HDR_PORT_W - COORD_W;
  localparam int DY_LSB  = DX_LSB - COORD_W;
  localparam int CYC_BIT = ADR_W + 6;

  ni_state_e                state, state_d;
  logic [FLIT_W-1:0]        chan_d;
  logic                     ack_d, err_d, is_we, is_we_d, data_pending, data_pending_d;
  logic                     rx_match, rx_match_d, load_vc0, credit_ok, timeout_hit;
  logic [31:0]              dat_d, wdata, wdata_d;
  logic [CW-1:0]            credit_vc0, credit_vc1;
  logic [PAYLOAD_W-1:0]     header, rx_pl;
  logic                     rx_valid, rx_head, rx_tail, rx_dest_ok, rx_done;
  region_t                  rgn;
  logic                     unused_bits;

  ni_credit_counter #(.DEPTH(CREDIT_DEPTH)) u_credit_vc0 (
    .clk(clk), .rst(rst), .take(load_vc0), .give(flow_ctrl_in[0]), .count(credit_vc0)
  );
  // Requests never travel on VC1; its counter only tracks returns from the router.
  ni_credit_counter #(.DEPTH(CREDIT_DEPTH)) u_credit_vc1 (
    .clk(clk), .rst(rst), .take(1'b0), .give(flow_ctrl_in[1]), .count(credit_vc1)
  );

  assign credit_ok      = credit_vc0 != '0;
  assign rgn            = region_decode(wb_adr_i[31:28]);
  assign header         = {xy_port(rgn.x, rgn.y, 8'(MY_X), 8'(MY_Y)),
                           rgn.x[COORD_W-1:0], rgn.y[COORD_W-1:0],
                           COORD_W'(MY_X), COORD_W'(MY_Y),
                           wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i[ADR_W-1:0]};

  assign rx_valid   = channel_in[FLIT_VALID];
  assign rx_head    = channel_in[FLIT_HEAD];
  assign rx_tail    = channel_in[FLIT_TAIL];
  assign rx_pl      = channel_in[FLIT_W-1:FLIT_PL_LSB];
  assign rx_dest_ok = (rx_pl[DX_LSB +: COORD_W] == COORD_W'(MY_X)) &&
                      (rx_pl[DY_LSB +: COORD_W] == COORD_W'(MY_Y));
  // Body flits inherit the routing verdict of the head that opened their packet.
  assign rx_done    = is_we ? (rx_valid && rx_head && rx_tail && rx_dest_ok && rx_pl[CYC_BIT])
                            : (rx_valid && rx_tail && (rx_head ? rx_dest_ok : rx_match));

`ifdef NI_RESP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt <= '0;
    else if (state == ST_WAIT && !timeout_hit) to_cnt <= to_cnt + 1'b1;
    else to_cnt <= '0;
  end

  assign timeout_hit = (state == ST_WAIT) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign unused_bits = ^wb_adr_i[27:ADR_W];
`else
  assign timeout_hit = 1'b0;
  assign unused_bits = ^{wb_adr_i[27:ADR_W], (TIMEOUT_CYC > 0)};
`endif

  always_comb begin
    state_d        = state;
    chan_d         = '0;
    ack_d          = 1'b0;
    err_d          = 1'b0;
    dat_d          = wb_dat_o;
    is_we_d        = is_we;
    wdata_d        = wdata;
    data_pending_d = data_pending;
    rx_match_d     = 1'b0;
    load_vc0       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o) begin
          if (!rgn.mapped) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (credit_ok) begin
            chan_d   = make_flit(header, !wb_we_i, 1'b1, 1'b0);
            load_vc0 = 1'b1;
            is_we_d  = wb_we_i;
            wdata_d  = wb_dat_i;
            state_d  = ST_HEAD;
          end
        end
      end
      ST_HEAD: begin
        if (is_we) begin
          state_d = ST_DATA;
          if (credit_ok) begin
            chan_d         = make_flit(wdata, 1'b1, 1'b0, 1'b0);
            load_vc0       = 1'b1;
            data_pending_d = 1'b0;
          end else begin
            data_pending_d = 1'b1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DATA: begin
        if (data_pending) begin
          if (credit_ok) begin
            chan_d         = make_flit(wdata, 1'b1, 1'b0, 1'b0);
            load_vc0       = 1'b1;
            data_pending_d = 1'b0;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        rx_match_d = (rx_valid && rx_head) ? rx_dest_ok : rx_match;
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (rx_done) begin
          ack_d   = 1'b1;
          state_d = ST_RESP;
          if (!is_we) dat_d = rx_pl;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      channel_out   <= '0;
      wb_ack_o      <= 1'b0;
      wb_err_o      <= 1'b0;
      wb_dat_o      <= '0;
      flow_ctrl_out <= '0;
      is_we         <= 1'b0;
      wdata         <= '0;
      data_pending  <= 1'b0;
      rx_match      <= 1'b0;
    end else begin
      state         <= state_d;
      channel_out   <= chan_d;
      wb_ack_o      <= ack_d;
      wb_err_o      <= err_d;
      wb_dat_o      <= dat_d;
      flow_ctrl_out <= {rx_valid & channel_in[FLIT_VC], rx_valid & ~channel_in[FLIT_VC]};
      is_we         <= is_we_d;
      wdata         <= wdata_d;
      data_pending  <= data_pending_d;
      rx_match      <= rx_match_d;
    end
  end

  assign dbg_state      = state;
  assign dbg_credit_vc0 = credit_vc0;
  assign dbg_credit_vc1 = credit_vc1;
endmodule

// File: tb/tb_ni_wb_master_bridge.sv
// Bench for ni_wb_master_bridge at node (0,0), CREDIT_DEPTH=3, TIMEOUT_CYC=16.
module tb_ni_wb_master_bridge;
  import ni_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] wb_dat_o;
  logic [35:0] channel_out, channel_in;
  logic [1:0]  flow_ctrl_in, flow_ctrl_out;
  ni_state_e   dbg_state;
  logic [1:0]  dbg_credit_vc0, dbg_credit_vc1;

  ni_wb_master_bridge #(
    .MY_X(0), .MY_Y(0), .COORD_W(2), .CREDIT_DEPTH(3), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_dat_o(wb_dat_o),
    .channel_out(channel_out), .channel_in(channel_in),
    .flow_ctrl_in(flow_ctrl_in), .flow_ctrl_out(flow_ctrl_out),
    .dbg_state(dbg_state), .dbg_credit_vc0(dbg_credit_vc0), .dbg_credit_vc1(dbg_credit_vc1)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [35:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every valid outgoing flit must match the oldest expected one.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (channel_out[0]) begin
        if (exp_q.size() == 0) check("unexpected_flit", 64'(channel_out), 64'd0);
        else check("flit", 64'(channel_out), 64'(exp_q.pop_front()));
      end
      if (wb_ack_o || wb_err_o) check("ack_err_excl", 64'(wb_ack_o & wb_err_o), 64'd0);
    end
  end

  function automatic logic [35:0] head_flit(input logic [31:0] adr, input logic we,
                                            input logic [3:0] sel, input logic [1:0] dx,
                                            input logic [1:0] dy, input logic [2:0] port);
    logic [31:0] pl;
    pl = {port, dx, dy, 2'd0, 2'd0, 1'b1, 1'b1, we, sel, adr[13:0]};
    return {pl, ~we, 1'b1, 1'b0, 1'b1};
  endfunction

  function automatic logic [35:0] dat_flit(input logic [31:0] d, input logic vc);
    return {d, 1'b1, 1'b0, vc, 1'b1};
  endfunction

  function automatic logic [35:0] rsp_head(input logic [1:0] dx, input logic [1:0] dy,
                                           input logic vc, input logic tail, input logic ok);
    logic [31:0] pl;
    pl        = '0;
    pl[28:27] = dx;
    pl[26:25] = dy;
    pl[20]    = ok;
    return {pl, tail, 1'b1, vc, 1'b1};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_req(input logic [31:0] adr, input logic we, input logic [31:0] d,
                        input logic [3:0] sel);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = d; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
  endtask

  task automatic wb_drop();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = '0;
  endtask

  task automatic start_req(input logic [31:0] adr, input logic we, input logic [31:0] d,
                           input logic [3:0] sel, input logic [1:0] dx, input logic [1:0] dy,
                           input logic [2:0] port);
    exp_q.push_back(head_flit(adr, we, sel, dx, dy, port));
    if (we) exp_q.push_back(dat_flit(d, 1'b0));
    wb_req(adr, we, d, sel);
    tick(1);
    check("head_latency", 64'(channel_out[0]), 64'd1);
  endtask

  task automatic send_flit(input logic [35:0] f, input logic [1:0] exp_fc);
    channel_in = f;
    tick(1);
    channel_in = '0;
    check("flow_ctrl_out", 64'(flow_ctrl_out), 64'(exp_fc));
  endtask

  task automatic credit_pulse(input logic [1:0] m);
    flow_ctrl_in = m;
    tick(1);
    flow_ctrl_in = '0;
  endtask

  task automatic finish_read(input logic [31:0] d, input string tag);
    send_flit(rsp_head(2'd0, 2'd0, 1'b0, 1'b0, 1'b0), 2'b01);
    check({tag, "_ack_early"}, 64'(wb_ack_o), 64'd0);
    send_flit(dat_flit(d, 1'b0), 2'b01);
    check({tag, "_ack"}, 64'(wb_ack_o), 64'd1);
    check({tag, "_dat"}, 64'(wb_dat_o), 64'(d));
    tick(1);
    check({tag, "_ack_pulse"}, 64'(wb_ack_o), 64'd0);
    wb_drop();
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          k;
    rst = 1'b1; channel_in = '0; flow_ctrl_in = '0; wb_adr_i = '0; wb_sel_i = '0;
    wb_drop();
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_chan", 64'(channel_out), 64'd0);
    check("rst_ack_err", 64'({wb_ack_o, wb_err_o}), 64'd0);
    check("rst_dat", 64'(wb_dat_o), 64'd0);
    check("rst_fc", 64'(flow_ctrl_out), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_credits", 64'({dbg_credit_vc0, dbg_credit_vc1}), 64'({2'd3, 2'd3}));

    // Read from region 0: dest (1,1), East, single head flit with tail set.
    start_req(32'h0000_0010, 1'b0, '0, 4'hF, 2'd1, 2'd1, PORT_EAST);
    check("rd_head_tail", 64'(channel_out[3]), 64'd1);
    tick(1);
    check("rd_state_wait", 64'(dbg_state), 64'(ST_WAIT));
    check("rd_credit", 64'(dbg_credit_vc0), 64'd2);
    finish_read(32'hDEAD_BEEF, "rd0");

    // Load coinciding with a credit return, then master abort in WAIT.
    flow_ctrl_in = 2'b01;
    start_req(32'h1000_0000, 1'b0, '0, 4'hF, 2'd2, 2'd1, PORT_EAST);
    flow_ctrl_in = '0;
    check("credit_load_and_return", 64'(dbg_credit_vc0), 64'd2);
    tick(1);
    wb_drop();
    tick(1);
    check("abort_wait_idle", 64'(dbg_state), 64'(ST_IDLE));
    send_flit(rsp_head(2'd0, 2'd0, 1'b0, 1'b0, 1'b0), 2'b01);
    send_flit(dat_flit(32'h5555_AAAA, 1'b0), 2'b01);
    check("late_reply_no_ack", 64'(wb_ack_o), 64'd0);
    check("late_reply_dat_hold", 64'(wb_dat_o), 64'hDEAD_BEEF);
    tick(1);

    // Read from region 2: dest (0,1), North.
    d = $urandom;
    start_req(32'h2000_0000 | 32'($urandom_range(0, 16383)) , 1'b0, '0, 4'hF, 2'd0, 2'd1, PORT_NORTH);
    tick(1);
    finish_read(d, "rd2");
    check("credit_one_left", 64'(dbg_credit_vc0), 64'd1);

    // Write with a single credit left: data flit waits for a return.
    start_req(32'h3000_0004, 1'b1, 32'h1234_5678, 4'hC, 2'd1, 2'd0, PORT_EAST);
    check("wr_head_tail", 64'(channel_out[3]), 64'd0);
    tick(1);
    check("wr_no_data_wo_credit", 64'(channel_out[0]), 64'd0);
    tick(2);
    check("wr_stall_state", 64'(dbg_state), 64'(ST_DATA));
    check("wr_stall_no_data", 64'(channel_out[0]), 64'd0);
    credit_pulse(2'b01);
    k = 0;
    while (k < 4 && !channel_out[0]) begin
      tick(1);
      k++;
    end
    check("wr_tail_after_credit", 64'(channel_out[0]), 64'd1);
    tick(1);
    check("wr_state_wait", 64'(dbg_state), 64'(ST_WAIT));
    send_flit(rsp_head(2'd0, 2'd0, 1'b0, 1'b1, 1'b0), 2'b01);
    check("wr_nack_bit_no_ack", 64'(wb_ack_o), 64'd0);
    send_flit(rsp_head(2'd0, 2'd0, 1'b0, 1'b1, 1'b1), 2'b01);
    check("wr_ack", 64'(wb_ack_o), 64'd1);
    tick(1);
    check("wr_ack_pulse", 64'(wb_ack_o), 64'd0);
    wb_drop();
    tick(1);

    // Credit saturation: four returns from zero at depth 3.
    check("credit_empty", 64'(dbg_credit_vc0), 64'd0);
    for (int i = 0; i < 4; i++) credit_pulse(2'b01);
    check("credit_sat_hi", 64'(dbg_credit_vc0), 64'd3);
    credit_pulse(2'b10);
    check("credit_vc1_sat", 64'(dbg_credit_vc1), 64'd3);

    // Unmapped region: error pulse, no flit, credits untouched.
    wb_req(32'h9000_0000, 1'b0, '0, 4'hF);
    tick(1);
    check("unmapped_err", 64'(wb_err_o), 64'd1);
    check("unmapped_no_ack", 64'(wb_ack_o), 64'd0);
    check("unmapped_no_flit", 64'(channel_out[0]), 64'd0);
    tick(1);
    check("unmapped_err_pulse", 64'(wb_err_o), 64'd0);
    wb_drop();
    tick(1);
    check("unmapped_credit", 64'(dbg_credit_vc0), 64'd3);

    // Misrouted replies are ignored but still return credit.
    start_req(32'h4000_0020, 1'b0, '0, 4'h3, 2'd1, 2'd2, PORT_EAST);
    tick(1);
    send_flit(rsp_head(2'd2, 2'd2, 1'b0, 1'b0, 1'b0), 2'b01);
    send_flit(dat_flit(32'hBAD0_BAD0, 1'b0), 2'b01);
    check("misroute_no_ack", 64'(wb_ack_o), 64'd0);
    send_flit(rsp_head(2'd2, 2'd2, 1'b1, 1'b1, 1'b1), 2'b10);
    check("misroute_vc1_no_ack", 64'(wb_ack_o), 64'd0);
    d = $urandom;
    finish_read(d, "rd4");

    // Master abort right after the head: the data flit still goes out, reply dropped.
    d = $urandom;
    start_req(32'h0000_0100, 1'b1, d, 4'hF, 2'd1, 2'd1, PORT_EAST);
    wb_drop();
    tick(1);
    check("abort_tail_sent", 64'(channel_out[0]), 64'd1);
    check("abort_tail_bit", 64'(channel_out[3]), 64'd1);
    tick(2);
    check("abort_idle", 64'(dbg_state), 64'(ST_IDLE));
    send_flit(rsp_head(2'd0, 2'd0, 1'b0, 1'b1, 1'b1), 2'b01);
    check("abort_wr_no_ack", 64'(wb_ack_o), 64'd0);
    for (int i = 0; i < 3; i++) credit_pulse(2'b01);
    check("credit_refill", 64'(dbg_credit_vc0), 64'd3);

`ifdef NI_RESP_TIMEOUT_EN
    start_req(32'h0000_0040, 1'b0, '0, 4'hF, 2'd1, 2'd1, PORT_EAST);
    tick(1);
    k = 0;
    for (int i = 0; i < 64; i++) begin
      if (wb_err_o) break;
      if (dbg_state == ST_WAIT) k++;
      tick(1);
    end
    check("timeout_err", 64'(wb_err_o), 64'd1);
    check("timeout_wait_cycles", 64'(k), 64'd16);
    tick(1);
    wb_drop();
    tick(1);
    send_flit(rsp_head(2'd0, 2'd0, 1'b0, 1'b1, 1'b0), 2'b01);
    check("timeout_late_no_ack", 64'(wb_ack_o), 64'd0);
`else
    start_req(32'h0000_0040, 1'b0, '0, 4'hF, 2'd1, 2'd1, PORT_EAST);
    tick(40);
    check("no_timeout_state", 64'(dbg_state), 64'(ST_WAIT));
    check("no_timeout_err", 64'(wb_err_o), 64'd0);
    wb_drop();
    tick(1);
    check("no_timeout_abort", 64'(dbg_state), 64'(ST_IDLE));
`endif

    // Reset in the middle of a write packet.
    start_req(32'h3000_0008, 1'b1, 32'hCAFE_F00D, 4'hF, 2'd1, 2'd0, PORT_EAST);
    channel_in = dat_flit(32'h1111_2222, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_chan", 64'(channel_out), 64'd0);
    check("midrst_ack_err", 64'({wb_ack_o, wb_err_o}), 64'd0);
    check("midrst_dat", 64'(wb_dat_o), 64'd0);
    check("midrst_fc", 64'(flow_ctrl_out), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("midrst_credit", 64'(dbg_credit_vc0), 64'd3);
    exp_q.delete();
    channel_in = '0;
    wb_drop();
    tick(2);
    rst = 1'b0;
    tick(3);
    check("post_rst_quiet", 64'(channel_out[0]), 64'd0);
    check("flit_q_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
